// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//   Consumes the raw q bus of an upstream ripple counter. A small stability
//   filter removes ripple-settling glitches. Each filtered step is turned into a
//   modular delta and accumulated into a wide running count with a sticky
//   overflow flag. An IDLE/ARMED/HOLD machine captures the running count once
//   it reaches a programmable threshold, then offers it over valid/ready.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous reset, active low
//   cnt_in     in   [CNT_W-1:0] raw counter bus (asynchronously settling)
//   enable     in   1 = accumulate filtered deltas, 0 = freeze ext_count
//   cnt_clear  in   clear ext_count/overflow and re-baseline to the filtered count
//   arm        in   start a threshold watch (only acted on in IDLE)
//   threshold  in   [W-1:0] unsigned capture level
//   ext_count  out  [W-1:0] extended running count
//   overflow   out  sticky carry-out of ext_count
//   match      out  one-cycle pulse when the capture fires
//   snap_valid out  snapshot available
//   snap_ready in   consumer accepts snapshot
//   snap_data  out  [W-1:0] captured ext_count
//   busy       out  state != IDLE
module ripple_count_capture #(
  parameter int CNT_W    = 4,
  parameter int EXT_W    = 12,
  parameter int STABLE_N = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         cnt_in,
  input  logic                     enable,
  input  logic                     cnt_clear,
  input  logic                     arm,
  input  logic [CNT_W+EXT_W-1:0]   threshold,
  output logic [CNT_W+EXT_W-1:0]   ext_count,
  output logic                     overflow,
  output logic                     match,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [CNT_W+EXT_W-1:0]   snap_data,
  output logic                     busy
);

  localparam int W     = CNT_W + EXT_W;
  localparam int RUN_W = (STABLE_N < 1) ? 1 : $clog2(STABLE_N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] s1_reg;
  logic [CNT_W-1:0] filt_reg;
  logic [RUN_W-1:0] run_reg;
  logic             stable;

  // run_reg = number of consecutive cycles s1_reg has held its current value,
  // saturating at STABLE_N.
  assign stable = (run_reg >= RUN_W'(STABLE_N));

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_reg   <= '0;
      run_reg  <= '0;
      filt_reg <= '0;
    end else begin
      s1_reg <= cnt_in;
      if (cnt_in != s1_reg) begin
        run_reg <= RUN_W'(1);
      end else if (!stable) begin
        run_reg <= run_reg + RUN_W'(1);
      end
      if (stable) begin
        filt_reg <= s1_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delta accumulation
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] base_reg;
  logic [W-1:0]     ext_count_reg;
  logic             overflow_reg;
  logic             filt_step;
  logic [CNT_W-1:0] delta;
  logic [W:0]       sum;

  // filt_step marks the cycle in which filt_reg takes a new value; the delta is
  // taken against the new value so the accumulator updates in the same edge.
  assign filt_step = stable && (s1_reg != filt_reg);
  // Modular subtraction: a 15->0 wrap yields 1, a skipped code yields 2, etc.
  assign delta     = s1_reg - base_reg;
  assign sum       = {1'b0, ext_count_reg} + (W+1)'(delta);

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_reg      <= '0;
      ext_count_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (cnt_clear) begin
      base_reg      <= filt_reg;
      ext_count_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (filt_step) begin
      // base follows the filtered count even while frozen, so re-enabling
      // never replays the steps seen while disabled.
      base_reg <= s1_reg;
      if (enable) begin
        ext_count_reg <= sum[W-1:0];
        if (sum[W]) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold capture FSM
  // ---------------------------------------------------------------------------
  state_t       state_reg, state_next;
  logic         match_reg, match_next;
  logic         snap_valid_reg, snap_valid_next;
  logic [W-1:0] snap_data_reg, snap_data_next;
  logic         busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      match_reg      <= 1'b0;
      snap_valid_reg <= 1'b0;
      snap_data_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      match_reg      <= match_next;
      snap_valid_reg <= snap_valid_next;
      snap_data_reg  <= snap_data_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    match_next      = 1'b0;
    snap_valid_next = snap_valid_reg;
    snap_data_next  = snap_data_reg;
    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        // Compare the registered count, so the snapshot equals the value
        // that satisfied the threshold.
        if (ext_count_reg >= threshold) begin
          state_next      = HOLD;
          match_next      = 1'b1;
          snap_valid_next = 1'b1;
          snap_data_next  = ext_count_reg;
        end
      end
      HOLD: begin
        if (snap_valid_reg && snap_ready) begin
          state_next      = IDLE;
          snap_valid_next = 1'b0;
        end
      end
      default: begin
        state_next      = IDLE;
        snap_valid_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign ext_count  = ext_count_reg;
  assign overflow   = overflow_reg;
  assign match      = match_reg;
  assign snap_valid = snap_valid_reg;
  assign snap_data  = snap_data_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Testbench for ripple_count_capture: default instance (W=16) plus an
// EXT_W=0 instance (W=4) for the wrap/overflow case. Expected counts and
// snapshots are queued when stimulus is applied and compared on output.
module tb_ripple_count_capture;

  logic        clk;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        enable;
  logic        cnt_clear;
  logic        arm;
  logic [15:0] threshold;
  logic [15:0] ext_count;
  logic        overflow;
  logic        match;
  logic        snap_valid;
  logic        snap_ready;
  logic [15:0] snap_data;
  logic        busy;

  logic [3:0]  cnt_in4;
  logic        cnt_clear4;
  logic [3:0]  ext_count4;
  logic        overflow4;
  logic        match4;
  logic        snap_valid4;
  logic [3:0]  snap_data4;
  logic        busy4;

  int          n_vec = 0;
  int          n_err = 0;
  int          match_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_ext;

  ripple_count_capture dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .enable(enable),
    .cnt_clear(cnt_clear), .arm(arm), .threshold(threshold),
    .ext_count(ext_count), .overflow(overflow), .match(match),
    .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_data(snap_data), .busy(busy)
  );

  ripple_count_capture #(.EXT_W(0)) dut4 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in4), .enable(1'b1),
    .cnt_clear(cnt_clear4), .arm(1'b0), .threshold(4'd0),
    .ext_count(ext_count4), .overflow(overflow4), .match(match4),
    .snap_valid(snap_valid4), .snap_ready(1'b0),
    .snap_data(snap_data4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (match === 1'b1) match_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (ext_count !== 16'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_count: ext_count=%0d overflow=%b, expected 0/0", ext_count, overflow);
    end
    n_vec++;
    if (snap_valid !== 1'b0 || match !== 1'b0 || busy !== 1'b0 || snap_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_fsm: snap_valid=%b match=%b busy=%b snap_data=%0d, expected all 0",
               snap_valid, match, busy, snap_data);
    end
    n_vec++;
    if (ext_count4 !== 4'd0 || overflow4 !== 1'b0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_w4: ext_count=%0d overflow=%b busy=%b, expected 0", ext_count4, overflow4, busy4);
    end
    $display("reset: ext_count=%0d busy=%b snap_valid=%b", ext_count, busy, snap_valid);
    exp_ext = 16'd0;
  endtask

  task automatic test_count();
    logic [3:0]  prev;
    logic [3:0]  v;
    logic [15:0] e;
    prev = 4'd0;
    for (int i = 1; i <= 17; i++) begin
      v = i[3:0];
      exp_ext = exp_ext + 16'((v - prev) & 4'hF);
      prev = v;
      exp_q.push_back(exp_ext);
      step(v, 4);
      if (v == 4'd3 && i < 16) begin
        // single-cycle glitch must not be accepted by the filter
        cnt_in = 4'hA;
        tick();
        step(4'd3, 4);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (ext_count !== e) begin
        n_err++;
        $display("FAIL count_step: cnt_in=%h ext_count=%0d expected %0d", v, ext_count, e);
      end
      $display("count: cnt_in=%h ext_count=%0d", v, ext_count);
    end
    n_vec++;
    if (ext_count !== 16'd17) begin
      n_err++;
      $display("FAIL count_total: ext_count=%0d expected 17", ext_count);
    end
  endtask

  task automatic test_capture();
    int          m0;
    logic [15:0] e;
    step(4'd0, 4);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    exp_ext = 16'd0;
    n_vec++;
    if (ext_count !== 16'd0) begin
      n_err++;
      $display("FAIL clear_main: ext_count=%0d expected 0", ext_count);
    end
    threshold = 16'd5;
    m0 = match_cnt;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || snap_valid !== 1'b0) begin
      n_err++;
      $display("FAIL armed: busy=%b snap_valid=%b expected 1/0", busy, snap_valid);
    end
    exp_q.push_back(16'd5);
    for (int i = 1; i <= 6; i++) step(4'(i), 4);
    exp_ext = 16'd6;
    n_vec++;
    if (match_cnt - m0 !== 1) begin
      n_err++;
      $display("FAIL match_pulse: pulses=%0d expected 1", match_cnt - m0);
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (snap_valid !== 1'b1 || snap_data !== exp_q[0] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold_stable: cycle=%0d snap_valid=%b snap_data=%0d busy=%b expected 1/%0d/1",
                 i, snap_valid, snap_data, busy, exp_q[0]);
      end
      tick();
    end
    snap_ready = 1'b1;
    e = exp_q.pop_front();
    n_vec++;
    if (snap_data !== e) begin
      n_err++;
      $display("FAIL snap_data: got %0d expected %0d", snap_data, e);
    end
    $display("capture: snap_data=%0d ext_count=%0d", snap_data, ext_count);
    tick();
    snap_ready = 1'b0;
    n_vec++;
    if (snap_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL handshake: snap_valid=%b busy=%b expected 0/0", snap_valid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] seq [4];
    logic       ovf [4];
    logic [3:0] e;
    seq = '{4'd14, 4'd15, 4'd0, 4'd1};
    ovf = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(seq[i]));
      cnt_in4 = seq[i];
      repeat (4) tick();
      e = 4'(exp_q.pop_front());
      n_vec++;
      if (ext_count4 !== e || overflow4 !== ovf[i]) begin
        n_err++;
        $display("FAIL wrap_step: cnt_in=%0d ext_count=%0d overflow=%b expected %0d/%b",
                 seq[i], ext_count4, overflow4, e, ovf[i]);
      end
      $display("wrap: cnt_in=%0d ext_count=%0d overflow=%b", seq[i], ext_count4, overflow4);
    end
    cnt_clear4 = 1'b1;
    tick();
    cnt_clear4 = 1'b0;
    n_vec++;
    if (ext_count4 !== 4'd0 || overflow4 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_clear: ext_count=%0d overflow=%b expected 0/0", ext_count4, overflow4);
    end
    n_vec++;
    if (match4 !== 1'b0 || snap_valid4 !== 1'b0 || snap_data4 !== 4'd0 || busy4 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_idle: match=%b snap_valid=%b snap_data=%0d busy=%b expected 0",
               match4, snap_valid4, snap_data4, busy4);
    end
  endtask

  task automatic test_enable();
    step(4'd3, 4);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    exp_ext = 16'd0;
    enable = 1'b0;
    step(4'd9, 4);
    n_vec++;
    if (ext_count !== exp_ext) begin
      n_err++;
      $display("FAIL enable_frozen: ext_count=%0d expected %0d", ext_count, exp_ext);
    end
    enable = 1'b1;
    exp_ext = exp_ext + 16'd1;
    exp_q.push_back(exp_ext);
    step(4'd10, 4);
    n_vec++;
    if (ext_count !== exp_q[0]) begin
      n_err++;
      $display("FAIL enable_resume: ext_count=%0d expected %0d", ext_count, exp_q[0]);
    end
    $display("enable: ext_count=%0d", ext_count);
    void'(exp_q.pop_front());
  endtask

  task automatic test_hold_reset();
    int m0;
    threshold = 16'd0;
    m0 = match_cnt;
    exp_q.push_back(exp_ext);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    n_vec++;
    if (match !== 1'b1 || snap_valid !== 1'b1 || snap_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL thresh0_fire: match=%b snap_valid=%b snap_data=%0d expected 1/1/%0d",
               match, snap_valid, snap_data, exp_q[0]);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b1 || snap_valid !== 1'b1 || snap_data !== exp_q[0] || match_cnt - m0 !== 1) begin
      n_err++;
      $display("FAIL arm_in_hold: busy=%b snap_valid=%b snap_data=%0d pulses=%0d expected 1/1/%0d/1",
               busy, snap_valid, snap_data, match_cnt - m0, exp_q[0]);
    end
    reset = 1'b0;
    tick();
    void'(exp_q.pop_front());
    n_vec++;
    if (busy !== 1'b0 || snap_valid !== 1'b0 || ext_count !== 16'd0) begin
      n_err++;
      $display("FAIL hold_reset: busy=%b snap_valid=%b ext_count=%0d expected 0/0/0",
               busy, snap_valid, ext_count);
    end
    $display("hold_reset: busy=%b snap_valid=%b", busy, snap_valid);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    cnt_in     = 4'd0;
    enable     = 1'b1;
    cnt_clear  = 1'b0;
    arm        = 1'b0;
    threshold  = 16'd0;
    snap_ready = 1'b0;
    cnt_in4    = 4'd0;
    cnt_clear4 = 1'b0;
    exp_ext    = 16'd0;
    test_reset();
    test_count();
    test_capture();
    test_overflow();
    test_enable();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
